// File: rtl/multiplier_pkg.sv
// ============================================================================
//  Module      : multiplier_pkg
//  Description : Shared types and constants for the sequential shift-add
//                multiplier: FSM state encoding, default operand widths and
//                the iteration-counter width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package multiplier_pkg;

    // Default operand widths (multiplicand M, multiplier N)
    localparam int M_DEFAULT = 26;
    localparam int N_DEFAULT = 14;

    // Two-state controller: waiting for a start, or iterating
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Counter must index 0..N-1; keep at least one bit when N == 1
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : multiplier_pkg

`default_nettype wire

// File: rtl/multiplier.sv
// ============================================================================
//  Module      : multiplier
//  Description : Unsigned M x N sequential shift-add multiplier, one
//                multiplier bit per clock. Start/keep-running via level 'en';
//                dropping 'en' while busy aborts without touching 'product'.
//                Optional macro EARLY_TERM_EN finishes as soon as the
//                remaining multiplier bits are all zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multiplier
    import multiplier_pkg::*;
#(
    parameter int M = M_DEFAULT,
    parameter int N = N_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [M-1:0]   multi1,
    input  logic [N-1:0]   multi2,
    output logic [M+N-1:0] product,
    output logic           done
);

    localparam int               CNT_W    = cnt_width(N);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    state_t           state_q;
    logic [M+N-1:0]   acc_q;
    logic [M+N-1:0]   a_sh_q;
    logic [N-1:0]     b_sh_q;
    logic [CNT_W-1:0] cnt_q;
    logic [M+N-1:0]   product_q;
    logic             done_q;

    logic [M+N-1:0]   partial_d;
    logic [M+N-1:0]   acc_d;
    logic [M+N-1:0]   a_sh_d;
    logic [N-1:0]     b_sh_d;
    logic             last_d;

    // One iteration of the shift-add step plus the "this is the final edge" test
    always_comb begin
        partial_d = b_sh_q[0] ? a_sh_q : '0;
        acc_d     = acc_q + partial_d;
        a_sh_d    = a_sh_q << 1;
        b_sh_d    = b_sh_q >> 1;
        last_d    = (cnt_q == LAST_CNT);
`ifdef EARLY_TERM_EN
        // Nothing left to add once the unconsumed multiplier bits are zero
        last_d    = last_d || (b_sh_d == '0);
`else
`endif
    end

    // Controller and datapath: load on start, iterate while en, publish on last step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (en) begin
                        a_sh_q  <= {{N{1'b0}}, multi1};
                        b_sh_q  <= multi2;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (!en) begin
                        // Abort: partial accumulator is simply abandoned
                        state_q <= IDLE;
                    end else begin
                        acc_q  <= acc_d;
                        a_sh_q <= a_sh_d;
                        b_sh_q <= b_sh_d;
                        cnt_q  <= cnt_q + CNT_W'(1);
                        if (last_d) begin
                            product_q <= acc_d;
                            done_q    <= 1'b1;
                            state_q   <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign product = product_q;
    assign done    = done_q;

endmodule : multiplier

`default_nettype wire

// File: tb/tb_multiplier.sv
// ============================================================================
//  Module      : tb_multiplier
//  Description : Self-checking bench for the sequential multiplier. Expected
//                products come from plain wide multiplication; expected
//                latency comes from the operand (fixed N, or MSB-based when
//                EARLY_TERM_EN is defined).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multiplier;

    localparam int M = 26;
    localparam int N = 14;
    localparam int P = M + N;

    logic         clk;
    logic         rst;
    logic         en;
    logic [M-1:0] multi1;
    logic [N-1:0] multi2;
    logic [P-1:0] product;
    logic         done;

    int vectors;
    int miscompares;

    // Last product the model believes has been published
    logic [P-1:0] model_product;

    multiplier #(.M(M), .N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .multi1  (multi1),
        .multi2  (multi2),
        .product (product),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Cycles from start edge to completion edge
    function automatic int latency(input logic [N-1:0] b);
`ifdef EARLY_TERM_EN
        int l;
        l = 1;
        for (int i = 0; i < N; i++) begin
            if (b[i]) l = i + 1;
        end
        return l;
`else
        return N;
`endif
    endfunction

    // Called at a negedge: starts an op, checks done timing and final product.
    // Returns at the negedge of the done cycle; en stays high if keep is set.
    task automatic do_op(input string tag, input logic [M-1:0] a, input logic [N-1:0] b,
                         input bit keep);
        int           l;
        logic [P-1:0] exp;
        l   = latency(b);
        exp = P'(a) * P'(b);
        multi1 = a;
        multi2 = b;
        en     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        // Change inputs while busy: the sampled operands must be used
        multi1 = ~a;
        multi2 = ~b;
        check({tag, "_busy_done"}, 64'(done), 64'd0);
        for (int k = 1; k <= l; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k < l) begin
                if (done !== 1'b0) check({tag, "_early_done"}, 64'(done), 64'd0);
            end
        end
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_product"}, 64'(product), 64'(exp));
        model_product = exp;
        if (!keep) en = 1'b0;
    endtask

    initial begin
        logic [M-1:0] ra;
        logic [N-1:0] rb;
        vectors       = 0;
        miscompares   = 0;
        model_product = '0;
        rst    = 1'b1;
        en     = 1'b0;
        multi1 = '0;
        multi2 = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_product", 64'(product), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed example from the datasheet
        do_op("dir", 26'h050A01, 14'h3024, 1'b0);
        check("dir_const", 64'(product), 64'hF2959824);
        @(negedge clk);
        check("dir_pulse_end", 64'(done), 64'd0);
        check("dir_hold", 64'(product), 64'(model_product));
        repeat (3) @(negedge clk);
        check("dir_hold_late", 64'(product), 64'(model_product));

        // Max x max
        do_op("max", {M{1'b1}}, {N{1'b1}}, 1'b0);
        check("max_const", 64'(product), 64'hFFFBFFC001);
        @(negedge clk);

        // Zero operands
        do_op("zero_a", '0, 14'h1ABC, 1'b0);
        @(negedge clk);
        do_op("zero_b", 26'h3ABCDEF, '0, 1'b0);
        @(negedge clk);

        // Small multiplier (early-termination case when enabled)
        do_op("one", 26'h123, 14'h1, 1'b0);
        @(negedge clk);

        // Back-to-back under continuous en: new operands sampled in done cycle
        do_op("b2b_1", 26'h1234567, 14'h2ACE, 1'b1);
        do_op("b2b_2", 26'h0FEDCBA, 14'h3F01, 1'b0);
        @(negedge clk);
        check("b2b_pulse_end", 64'(done), 64'd0);

        // Randomized operands against the arithmetic model
        for (int i = 0; i < 10; i++) begin
            ra = M'($urandom());
            rb = N'($urandom());
            do_op("rand", ra, rb, (i % 3) == 1);
        end
        en = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Abort mid-busy: no done, product unchanged
        multi1 = 26'h2222222;
        multi2 = 14'h2001;
        en     = 1'b1;
        repeat (5) @(negedge clk);
        en = 1'b0;
        for (int k = 0; k < N + 3; k++) begin
            @(negedge clk);
            if (done !== 1'b0) check("abort_done", 64'(done), 64'd0);
        end
        check("abort_product", 64'(product), 64'(model_product));
        check("abort_done_final", 64'(done), 64'd0);

        // Restart cleanly after abort
        do_op("post_abort", 26'h00ABCDE, 14'h2F0F, 1'b0);
        @(negedge clk);

        // Reset mid-busy: asynchronous clear, no partial result
        multi1 = 26'h3FFFFFF;
        multi2 = 14'h3FFF;
        en     = 1'b1;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_product", 64'(product), 64'd0);
        check("rst_mid_done", 64'(done), 64'd0);
        en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < N + 3; k++) begin
            @(negedge clk);
            if (done !== 1'b0) check("rst_after_done", 64'(done), 64'd0);
        end
        check("rst_after_product", 64'(product), 64'd0);

        // Normal operation resumes after reset
        do_op("post_rst", 26'h0000F0F, 14'h00FF, 1'b0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation did not finish");
    end

endmodule : tb_multiplier

`default_nettype wire
